rr_prio_arbiter: RTL and testbench

- Shares a single downstream resource among N requesters, one owner at a time.
- Two selectable policies: fixed priority (highest index wins, matching the priority-encoder convention) and round-robin.
- Grant is registered and held until the owner signals done or drops its request.
- Sits in front of the shared datapath unit. It also drives the unit's select index and valid.

---
 rtl/arb_pkg.sv | 19 +
 rtl/prio_pick.sv | 67 ++++++
 rtl/rr_prio_arbiter.sv | 168 ++++++++++++++++
 tb/tb_rr_prio_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared types and default sizing for the round-robin / priority arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE, GRANT, RELEASE)
//   N_DEF       : default number of requesters
//   IDW_DEF     : default width of the grant index
// ---------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        RELEASE = 2'b10
    } arb_state_e;

    localparam int N_DEF   = 32'sd6;
    localparam int IDW_DEF = 32'sd3;

endpackage

// File: rtl/prio_pick.sv
// ---------------------------------------------------------------------------
// prio_pick
// Purely combinational masked priority encoder used by rr_prio_arbiter.
//   req       [N-1:0]   : request vector
//   ptr       [IDW-1:0] : round-robin start index (searched first, downward)
//   mode                : 0 = highest set index wins, 1 = round-robin from ptr
//   winner    [IDW-1:0] : index of the selected requester (0 when none)
//   any_valid           : at least one request is set
// ---------------------------------------------------------------------------
module prio_pick
    import arb_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int IDW = IDW_DEF
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           mode,
    output logic [IDW-1:0] winner,
    output logic           any_valid
);

    logic           found_s;
    logic [IDW-1:0] idx_s;
    int             pos_s;

    // Any request present.
    always_comb begin
        any_valid = |req;
    end

    // Winner search: ascending scan keeps the last (highest) hit in fixed mode;
    // in round-robin mode scan downward from ptr with wrap 0 -> N-1, first hit wins.
    always_comb begin
        winner  = {IDW{1'b0}};
        found_s = 1'b0;
        idx_s   = {IDW{1'b0}};
        pos_s   = 32'sd0;
        if (mode == 1'b0) begin
            for (int i = 32'sd0; i < N; i++) begin
                idx_s = IDW'(i);
                if (req[idx_s]) begin
                    winner = idx_s;
                end else begin
                    winner = winner;
                end
            end
        end else begin
            for (int i = 32'sd0; i < N; i++) begin
                pos_s = int'(ptr) - i;
                if (pos_s < 32'sd0) begin
                    pos_s = pos_s + N;
                end else begin
                    pos_s = pos_s;
                end
                idx_s = IDW'(pos_s);
                if (!found_s && req[idx_s]) begin
                    winner  = idx_s;
                    found_s = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

endmodule

// File: rtl/rr_prio_arbiter.sv
// ---------------------------------------------------------------------------
// rr_prio_arbiter
// Grants a shared downstream unit to one of N requesters at a time, using
// either fixed priority (highest index) or round-robin selection. The grant
// is registered, held until done or the owner drops its request, and followed
// by one dead RELEASE cycle. Optional build macro ARB_TIMEOUT_EN caps the
// grant length at MAX_HOLD cycles and adds the timeout output.
//   clk     : system clock, rising edge
//   rst_b   : asynchronous active-low reset
//   req     : request vector, bit k = requester k
//   done    : owner finished (only meaningful in GRANT)
//   mode    : 0 = fixed priority, 1 = round-robin (sampled in IDLE)
//   gnt     : one-hot registered grant
//   gnt_id  : binary index of the granted requester
//   gnt_v   : grant valid (equals |gnt)
//   busy    : high in GRANT and RELEASE
//   timeout : (ARB_TIMEOUT_EN only) high for a RELEASE caused by expiry
// ---------------------------------------------------------------------------
module rr_prio_arbiter
    import arb_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int IDW = IDW_DEF
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int MAX_HOLD = 32'sd15
`endif
) (
    input  logic           clk,
    input  logic           rst_b,
    input  logic [N-1:0]   req,
    input  logic           done,
    input  logic           mode,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_v,
`ifdef ARB_TIMEOUT_EN
    output logic           timeout,
`endif
    output logic           busy
);

    localparam logic [N-1:0] ONE_HOT_BASE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [IDW-1:0] LAST_IDX   = IDW'(N - 32'sd1);

    arb_state_e     state_r;
    logic [IDW-1:0] ptr_r;
    logic [IDW-1:0] winner_s;
    logic           any_valid_s;
    logic           owner_req_s;
    logic           release_s;
`ifdef ARB_TIMEOUT_EN
    localparam logic [IDW+1:0] HOLD_LAST = (IDW+2)'(MAX_HOLD - 32'sd1);
    logic [IDW+1:0] hold_cnt_r;
    logic           expire_s;
`endif

    prio_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_prio_pick (
        .req       (req),
        .ptr       (ptr_r),
        .mode      (mode),
        .winner    (winner_s),
        .any_valid (any_valid_s)
    );

    // The owner still requests when its own bit is set in req.
    always_comb begin
        owner_req_s = |(req & gnt);
    end

`ifdef ARB_TIMEOUT_EN
    // Expiry fires on the last allowed GRANT cycle so the grant lasts MAX_HOLD cycles.
    always_comb begin
        if (state_r == GRANT) begin
            expire_s = (hold_cnt_r == HOLD_LAST);
        end else begin
            expire_s = 1'b0;
        end
    end

    // Any single cause ends the grant; coincident causes still give one release.
    always_comb begin
        release_s = done | ~owner_req_s | expire_s;
    end
`else
    // done and a dropped request share one release path, so coincident causes give one release.
    always_comb begin
        release_s = done | ~owner_req_s;
    end
`endif

    // Arbiter FSM with all registered outputs and the round-robin pointer.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r    <= IDLE;
            ptr_r      <= {IDW{1'b0}};
            gnt        <= {N{1'b0}};
            gnt_id     <= {IDW{1'b0}};
            gnt_v      <= 1'b0;
            busy       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_r <= {(IDW+2){1'b0}};
            timeout    <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_valid_s) begin
                        state_r <= GRANT;
                        gnt     <= ONE_HOT_BASE << winner_s;
                        gnt_id  <= winner_s;
                        gnt_v   <= 1'b1;
                        busy    <= 1'b1;
                        // Just-served requester becomes lowest priority next round.
                        if (mode) begin
                            ptr_r <= (winner_s == {IDW{1'b0}}) ? LAST_IDX
                                                              : winner_s - {{(IDW-1){1'b0}}, 1'b1};
                        end else begin
                            ptr_r <= ptr_r;
                        end
`ifdef ARB_TIMEOUT_EN
                        hold_cnt_r <= {(IDW+2){1'b0}};
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT: begin
                    if (release_s) begin
                        state_r <= RELEASE;
                        gnt     <= {N{1'b0}};
                        gnt_v   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                        timeout <= expire_s;
`endif
                    end else begin
                        state_r <= GRANT;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt_r <= hold_cnt_r + {{(IDW+1){1'b0}}, 1'b1};
`endif
                    end
                end
                RELEASE: begin
                    // gnt_id deliberately keeps the last owner through the dead cycle.
                    state_r <= IDLE;
                    busy    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                    timeout <= 1'b0;
`endif
                end
                default: begin
                    state_r <= IDLE;
                    gnt     <= {N{1'b0}};
                    gnt_id  <= {IDW{1'b0}};
                    gnt_v   <= 1'b0;
                    busy    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                    timeout <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_prio_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_prio_arbiter
// Directed testbench for rr_prio_arbiter with hand-computed expectations.
// Observed vector in each check is {gnt, gnt_id, gnt_v, busy}.
// Build with ARB_TIMEOUT_EN defined to also cover the hold timeout (MAX_HOLD=4).
// ---------------------------------------------------------------------------
module tb_rr_prio_arbiter;

    logic       clk;
    logic       rst_b;
    logic [5:0] req;
    logic       done;
    logic       mode;
    logic [5:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_v;
    logic       busy;
`ifdef ARB_TIMEOUT_EN
    logic       timeout;
`endif

    int checks_total;
    int checks_passed;

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef ARB_TIMEOUT_EN
    rr_prio_arbiter #(.N(6), .IDW(3), .MAX_HOLD(4)) dut (
        .clk(clk), .rst_b(rst_b), .req(req), .done(done), .mode(mode),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_v(gnt_v), .timeout(timeout), .busy(busy)
    );
`else
    rr_prio_arbiter #(.N(6), .IDW(3)) dut (
        .clk(clk), .rst_b(rst_b), .req(req), .done(done), .mode(mode),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_v(gnt_v), .busy(busy)
    );
`endif

    // Advance to 1 ns after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drop all requests and let the arbiter settle back into IDLE.
    task automatic go_idle();
        req  = 6'b000000;
        done = 1'b0;
        cyc();
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        req   = 6'b111111;
        done  = 1'b0;
        mode  = 1'b0;
        cyc();
        cyc();
        checks_total++;
        if ({gnt, gnt_id, gnt_v, busy} !== {6'b000000, 3'd0, 1'b0, 1'b0})
            $display("FAIL reset_state: got %b want %b", {gnt, gnt_id, gnt_v, busy}, {6'b000000, 3'd0, 1'b0, 1'b0});
        else checks_passed++;
`ifdef ARB_TIMEOUT_EN
        checks_total++;
        if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout);
        else checks_passed++;
`endif
        rst_b = 1'b1;
        cyc();
        checks_total++;
        if ({gnt, gnt_id, gnt_v, busy} !== {6'b100000, 3'd5, 1'b1, 1'b1})
            $display("FAIL reset_first_grant: got %b want %b", {gnt, gnt_id, gnt_v, busy}, {6'b100000, 3'd5, 1'b1, 1'b1});
        else checks_passed++;
        go_idle();
    endtask

    task automatic test_fixed_priority();
        mode = 1'b0;
        req  = 6'b010110;
        cyc();
        checks_total++;
        if ({gnt, gnt_id, gnt_v, busy} !== {6'b010000, 3'd4, 1'b1, 1'b1})
            $display("FAIL fixed_grant: got %b want %b", {gnt, gnt_id, gnt_v, busy}, {6'b010000, 3'd4, 1'b1, 1'b1});
        else checks_passed++;
        done = 1'b1;
        cyc();
        checks_total++;
        if ({gnt, gnt_id, gnt_v, busy} !== {6'b000000, 3'd4, 1'b0, 1'b1})
            $display("FAIL fixed_release: got %b want %b", {gnt, gnt_id, gnt_v, busy}, {6'b000000, 3'd4, 1'b0, 1'b1});
        else checks_passed++;
        done = 1'b0;
        cyc();
        checks_total++;
        if ({gnt, gnt_v, busy} !== {6'b000000, 1'b0, 1'b0})
            $display("FAIL fixed_idle: got %b want %b", {gnt, gnt_v, busy}, {6'b000000, 1'b0, 1'b0});
        else checks_passed++;
        cyc();
        checks_total++;
        if ({gnt, gnt_id, gnt_v, busy} !== {6'b010000, 3'd4, 1'b1, 1'b1})
            $display("FAIL fixed_regrant: got %b want %b", {gnt, gnt_id, gnt_v, busy}, {6'b010000, 3'd4, 1'b1, 1'b1});
        else checks_passed++;
        go_idle();
    endtask

    task automatic test_done_outside_grant();
        req  = 6'b000000;
        done = 1'b1;
        cyc();
        cyc();
        checks_total++;
        if ({gnt, gnt_v, busy} !== {6'b000000, 1'b0, 1'b0})
            $display("FAIL done_in_idle: got %b want %b", {gnt, gnt_v, busy}, {6'b000000, 1'b0, 1'b0});
        else checks_passed++;
        done = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [2:0] order [7];
        logic [5:0] exp_gnt;
        order = '{3'd0, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        mode = 1'b1;
        req  = 6'b111111;
        for (int k = 0; k < 7; k++) begin
            cyc();
            exp_gnt = 6'b000001 << order[k];
            checks_total++;
            if ({gnt, gnt_id} !== {exp_gnt, order[k]})
                $display("FAIL rr_order[%0d]: got gnt=%b id=%0d want gnt=%b id=%0d", k, gnt, gnt_id, exp_gnt, order[k]);
            else checks_passed++;
            done = 1'b1;
            cyc();
            done = 1'b0;
            cyc();
        end
        req = 6'b000000;
        cyc();
        // ptr is now 5; serving 4 moves it to 3.
        req = 6'b010000;
        cyc();
        checks_total++;
        if ({gnt, gnt_id} !== {6'b010000, 3'd4})
            $display("FAIL rr_serve4: got %b want %b", {gnt, gnt_id}, {6'b010000, 3'd4});
        else checks_passed++;
        done = 1'b1;
        cyc();
        done = 1'b0;
        req  = 6'b110001;
        mode = 1'b0;
        cyc();
        cyc();
        checks_total++;
        if ({gnt, gnt_id} !== {6'b100000, 3'd5})
            $display("FAIL mode0_with_ptr3: got %b want %b", {gnt, gnt_id}, {6'b100000, 3'd5});
        else checks_passed++;
        // Mode flips mid-grant: grant must hold, new mode used at next IDLE.
        mode = 1'b1;
        cyc();
        checks_total++;
        if ({gnt, gnt_id, busy} !== {6'b100000, 3'd5, 1'b1})
            $display("FAIL mode_change_hold: got %b want %b", {gnt, gnt_id, busy}, {6'b100000, 3'd5, 1'b1});
        else checks_passed++;
        done = 1'b1;
        cyc();
        done = 1'b0;
        cyc();
        cyc();
        checks_total++;
        if ({gnt, gnt_id} !== {6'b000001, 3'd0})
            $display("FAIL rr_ptr3_example: got %b want %b", {gnt, gnt_id}, {6'b000001, 3'd0});
        else checks_passed++;
        go_idle();
    endtask

    task automatic test_request_drop();
        mode = 1'b0;
        req  = 6'b000100;
        cyc();
        checks_total++;
        if ({gnt, gnt_id} !== {6'b000100, 3'd2})
            $display("FAIL drop_owner2: got %b want %b", {gnt, gnt_id}, {6'b000100, 3'd2});
        else checks_passed++;
        req = 6'b100100;
        cyc();
        checks_total++;
        if ({gnt, gnt_id, busy} !== {6'b000100, 3'd2, 1'b1})
            $display("FAIL nonowner_ignored: got %b want %b", {gnt, gnt_id, busy}, {6'b000100, 3'd2, 1'b1});
        else checks_passed++;
        req = 6'b100000;
        cyc();
        checks_total++;
        if ({gnt, gnt_id, gnt_v, busy} !== {6'b000000, 3'd2, 1'b0, 1'b1})
            $display("FAIL drop_release: got %b want %b", {gnt, gnt_id, gnt_v, busy}, {6'b000000, 3'd2, 1'b0, 1'b1});
        else checks_passed++;
        cyc();
        checks_total++;
        if ({gnt, busy} !== {6'b000000, 1'b0})
            $display("FAIL drop_idle: got %b want %b", {gnt, busy}, {6'b000000, 1'b0});
        else checks_passed++;
        cyc();
        checks_total++;
        if ({gnt, gnt_id} !== {6'b100000, 3'd5})
            $display("FAIL drop_next_winner: got %b want %b", {gnt, gnt_id}, {6'b100000, 3'd5});
        else checks_passed++;
        // done and request drop together: one release, then plain IDLE.
        done = 1'b1;
        req  = 6'b000000;
        cyc();
        checks_total++;
        if ({gnt, gnt_v, busy} !== {6'b000000, 1'b0, 1'b1})
            $display("FAIL both_release: got %b want %b", {gnt, gnt_v, busy}, {6'b000000, 1'b0, 1'b1});
        else checks_passed++;
        done = 1'b0;
        cyc();
        cyc();
        checks_total++;
        if ({gnt, gnt_v, busy} !== {6'b000000, 1'b0, 1'b0})
            $display("FAIL both_single_event: got %b want %b", {gnt, gnt_v, busy}, {6'b000000, 1'b0, 1'b0});
        else checks_passed++;
    endtask

    task automatic test_async_reset();
        // ptr is 5 here; serving 3 in round-robin moves it to 2.
        mode = 1'b1;
        req  = 6'b001000;
        cyc();
        checks_total++;
        if ({gnt, gnt_id} !== {6'b001000, 3'd3})
            $display("FAIL async_pre_grant: got %b want %b", {gnt, gnt_id}, {6'b001000, 3'd3});
        else checks_passed++;
        #2;
        rst_b = 1'b0;
        #1;
        checks_total++;
        if ({gnt, gnt_id, gnt_v, busy} !== {6'b000000, 3'd0, 1'b0, 1'b0})
            $display("FAIL async_reset_drop: got %b want %b", {gnt, gnt_id, gnt_v, busy}, {6'b000000, 3'd0, 1'b0, 1'b0});
        else checks_passed++;
        cyc();
        rst_b = 1'b1;
        req   = 6'b001010;
        cyc();
        // ptr back at 0: search 0,5,4,3 -> 3 (a stale ptr of 2 would pick 1).
        checks_total++;
        if ({gnt, gnt_id} !== {6'b001000, 3'd3})
            $display("FAIL async_ptr_cleared: got %b want %b", {gnt, gnt_id}, {6'b001000, 3'd3});
        else checks_passed++;
        go_idle();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        mode = 1'b0;
        done = 1'b0;
        req  = 6'b000010;
        for (int k = 0; k < 4; k++) begin
            cyc();
            checks_total++;
            if ({gnt, timeout} !== {6'b000010, 1'b0})
                $display("FAIL timeout_hold[%0d]: got %b want %b", k, {gnt, timeout}, {6'b000010, 1'b0});
            else checks_passed++;
        end
        cyc();
        checks_total++;
        if ({gnt, busy, timeout} !== {6'b000000, 1'b1, 1'b1})
            $display("FAIL timeout_expire: got %b want %b", {gnt, busy, timeout}, {6'b000000, 1'b1, 1'b1});
        else checks_passed++;
        cyc();
        checks_total++;
        if ({gnt, busy, timeout} !== {6'b000000, 1'b0, 1'b0})
            $display("FAIL timeout_idle: got %b want %b", {gnt, busy, timeout}, {6'b000000, 1'b0, 1'b0});
        else checks_passed++;
        cyc();
        checks_total++;
        if ({gnt, gnt_id, timeout} !== {6'b000010, 3'd1, 1'b0})
            $display("FAIL timeout_regrant: got %b want %b", {gnt, gnt_id, timeout}, {6'b000010, 3'd1, 1'b0});
        else checks_passed++;
        go_idle();
    endtask
`endif

    // Scenario sequence and summary.
    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst_b = 1'b0;
        req   = 6'b000000;
        done  = 1'b0;
        mode  = 1'b0;
        test_reset();
        test_fixed_priority();
        test_done_outside_grant();
        test_round_robin();
        test_request_drop();
        test_async_reset();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
